tppe_spike_accumulator: RTL and testbench

//  Producer side of the LIF input interface. Consumes a stream of (T-bit spike vector,

---
 rtl/tppe_pkg.sv | 17 +
 rtl/tppe_acc_lane.sv | 50 +++++
 rtl/tppe_spike_accumulator.sv | 97 +++++++++
 tb/tb_tppe_spike_accumulator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tppe_pkg.sv
// Purpose: shared defaults and state encoding for the TPPE spike accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default T/Q/W lane geometry and the two-state accumulator FSM enum.
// Build option: TPPE_ACC_SAT_EN (consumed by tppe_acc_lane) selects saturating lanes.
package tppe_pkg;

  localparam int T_DEF = 4;   // timesteps per spike vector / lanes
  localparam int Q_DEF = 10;  // lane width, matches LIF input quantisation
  localparam int W_DEF = 8;   // unsigned weight width, must be <= Q

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

endpackage

// File: rtl/tppe_acc_lane.sv
// Purpose: one Q-bit membrane-current lane; adds the weight when this lane's spike bit is set.
// Latency: sum visible on lane one cycle after add_en.
// Backpressure: none; the parent decides when add_en/clear fire.
// Ports: clk, rst (async active-high), clear (zero lane), add_en (accept beat),
//        spike (this lane's spike bit), weight (W-bit unsigned), lane (registered value),
//        carry (combinational: this beat's add exceeds 2^Q-1).
// Build option: TPPE_ACC_SAT_EN clamps to 2^Q-1 on overflow; otherwise the lane wraps mod 2^Q.
import tppe_pkg::*;

module tppe_acc_lane #(
  parameter int Q = Q_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         add_en,
  input  logic         spike,
  input  logic [W-1:0] weight,
  output logic [Q-1:0] lane,
  output logic         carry
);

  logic [W-1:0] gated_w;
  logic [Q:0]   sum;
  logic [Q-1:0] lane_d;

  always_comb begin
    gated_w = spike ? weight : '0;
    // One extra bit holds the carry-out so overflow is detected without a compare.
    sum     = {1'b0, lane} + {{(Q + 1 - W){1'b0}}, gated_w};
    carry   = add_en & sum[Q];
`ifdef TPPE_ACC_SAT_EN
    lane_d  = sum[Q] ? {Q{1'b1}} : sum[Q-1:0];
`else
    lane_d  = sum[Q-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (add_en) begin
      lane <= lane_d;
    end
  end

endmodule

// File: rtl/tppe_spike_accumulator.sv
// Purpose: accumulates (spike vector, weight) beats into T lanes and hands the packed word to the LIF.
// Latency: last beat accepted at edge k -> result_val and final result_data from cycle k+1.
// Backpressure: in_ready low while a result is held; held until result_ack, ack cycle is a bubble.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_spikes/in_weight/in_last input beats;
//        result_val/result_data/result_ack output handshake; acc_ovf sticky lane overflow flag.
// Build option: TPPE_ACC_SAT_EN selects saturating lanes (default: wrap, acc_ovf still flags).
import tppe_pkg::*;

module tppe_spike_accumulator #(
  parameter int T = T_DEF,
  parameter int Q = Q_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T-1:0]   in_spikes,
  input  logic [W-1:0]   in_weight,
  input  logic           in_last,
  output logic           result_val,
  output logic [T*Q-1:0] result_data,
  input  logic           result_ack,
  output logic           acc_ovf
);

  acc_state_e   state_q, state_d;
  logic         add_en;
  logic         clear;
  logic [T-1:0] carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready/result_val decode straight from the state flop, so neither
  // depends combinationally on any input.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    result_val = 1'b0;
    add_en     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        add_en   = in_valid;
        if (in_valid && in_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // in_valid is not looked at here; the beat stays with the producer.
        result_val = 1'b1;
        if (result_ack) begin
          clear   = 1'b1;
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // Lanes feed result_data directly: the output is the register contents.
  for (genvar t = 0; t < T; t++) begin : g_lane
    tppe_acc_lane #(
      .Q(Q),
      .W(W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .add_en (add_en),
      .spike  (in_spikes[t]),
      .weight (in_weight),
      .lane   (result_data[(t+1)*Q-1 -: Q]),
      .carry  (carry[t])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_ovf <= 1'b0;
    end else if (clear) begin
      acc_ovf <= 1'b0;
    end else if (|carry) begin
      acc_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tppe_spike_accumulator.sv
// Purpose: self-checking bench for tppe_spike_accumulator (T=4, Q=10, W=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_tppe_spike_accumulator;

  localparam int T    = 4;
  localparam int Q    = 10;
  localparam int W    = 8;
  localparam int LMAX = (1 << Q) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [T-1:0]   in_spikes = '0;
  logic [W-1:0]   in_weight = '0;
  logic           in_last = 1'b0;
  logic           result_val;
  logic [T*Q-1:0] result_data;
  logic           result_ack = 1'b0;
  logic           acc_ovf;

  int check_cnt = 0;
  int pass_cnt  = 0;

  tppe_spike_accumulator #(.T(T), .Q(Q), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_spikes   (in_spikes),
    .in_weight   (in_weight),
    .in_last     (in_last),
    .result_val  (result_val),
    .result_data (result_data),
    .result_ack  (result_ack),
    .acc_ovf     (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the exact (unbounded) per-lane sum of the current neuron; the visible
  // lane value and overflow flag are derived from it when compared.
  int   tot [T];
  logic m_hold = 1'b0;

  initial for (int i = 0; i < T; i++) tot[i] = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 1'b0;
      for (int i = 0; i < T; i++) tot[i] <= 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        for (int i = 0; i < T; i++) tot[i] <= tot[i] + (in_spikes[i] ? int'(in_weight) : 0);
        if (in_last) m_hold <= 1'b1;
      end
    end else if (result_ack) begin
      m_hold <= 1'b0;
      for (int i = 0; i < T; i++) tot[i] <= 0;
    end
  end

  function automatic int visible(input int total);
`ifdef TPPE_ACC_SAT_EN
    return (total > LMAX) ? LMAX : total;
`else
    return total % (LMAX + 1);
`endif
  endfunction

  function automatic logic [T*Q-1:0] model_word();
    logic [T*Q-1:0] w;
    int v;
    w = '0;
    for (int i = 0; i < T; i++) begin
      v = visible(tot[i]);
      w[i*Q +: Q] = v[Q-1:0];
    end
    return w;
  endfunction

  function automatic logic model_ovf();
    logic o;
    o = 1'b0;
    for (int i = 0; i < T; i++) if (tot[i] > LMAX) o = 1'b1;
    return o;
  endfunction

  function automatic logic [T*Q-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [T*Q-1:0] w;
    w = '0;
    w[0*Q +: Q] = l0[Q-1:0];
    w[1*Q +: Q] = l1[Q-1:0];
    w[2*Q +: Q] = l2[Q-1:0];
    w[3*Q +: Q] = l3[Q-1:0];
    return w;
  endfunction

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",    {63'd0, in_ready},   {63'd0, ~m_hold});
    chk("result_val",  {63'd0, result_val}, {63'd0, m_hold});
    chk("result_data", 64'(result_data),    64'(model_word()));
    chk("acc_ovf",     {63'd0, acc_ovf},    {63'd0, model_ovf()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [T-1:0] s, input logic [W-1:0] w, input logic last);
    in_valid  = 1'b1;
    in_spikes = s;
    in_weight = w;
    in_last   = last;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [T*Q-1:0] held;

  initial begin
    // Test 1: partial neuron, then reset held three cycles.
    idle(2);
    rst = 1'b0;
    idle(1);
    beat(4'b1111, 8'd9, 1'b0);
    rst = 1'b1;
    idle(3);
    chk("t1_in_ready",    {63'd0, in_ready},   64'd1);
    chk("t1_result_val",  {63'd0, result_val}, 64'd0);
    chk("t1_result_data", 64'(result_data),    64'd0);
    chk("t1_acc_ovf",     {63'd0, acc_ovf},    64'd0);
    rst = 1'b0;
    idle(1);

    // Test 2: three-beat neuron.
    beat(4'b1111, 8'd5, 1'b0);
    beat(4'b0101, 8'd10, 1'b0);
    beat(4'b1000, 8'd3, 1'b1);
    chk("t2_result_val",  {63'd0, result_val}, 64'd1);
    chk("t2_result_data", 64'(result_data),    64'(pack(15, 5, 15, 8)));

    // Test 3: valid driven while holding is ignored; ack together with valid wins.
    held = result_data;
    in_valid  = 1'b1;
    in_spikes = 4'b1111;
    in_weight = 8'd77;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t3_in_ready", {63'd0, in_ready},  64'd0);
      chk("t3_data",     64'(result_data),   64'(held));
    end
    ack();
    in_valid = 1'b0;
    chk("t3_ack_val",   {63'd0, result_val}, 64'd0);
    chk("t3_ack_data",  64'(result_data),    64'd0);
    chk("t3_ack_ready", {63'd0, in_ready},   64'd1);

    // Test 4: lane 0 overflows.
    repeat (4) beat(4'b0001, 8'd255, 1'b0);
    beat(4'b0001, 8'd255, 1'b1);
`ifdef TPPE_ACC_SAT_EN
    chk("t4_data", 64'(result_data), 64'(pack(1023, 0, 0, 0)));
`else
    chk("t4_data", 64'(result_data), 64'(pack(251, 0, 0, 0)));
`endif
    chk("t4_ovf", {63'd0, acc_ovf}, 64'd1);
    ack();
    chk("t4_ovf_clr", {63'd0, acc_ovf}, 64'd0);

    // Test 5: single all-zero-spike beat still completes a neuron.
    beat(4'b0000, 8'd200, 1'b1);
    chk("t5_val",  {63'd0, result_val}, 64'd1);
    chk("t5_data", 64'(result_data),    64'd0);
    chk("t5_ovf",  {63'd0, acc_ovf},    64'd0);
    ack();

    // Test 6: reset pulse mid-neuron, then a fresh neuron.
    beat(4'b0011, 8'd40, 1'b0);
    beat(4'b0111, 8'd50, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    beat(4'b0010, 8'd7, 1'b1);
    chk("t6_val",  {63'd0, result_val}, 64'd1);
    chk("t6_data", 64'(result_data),    64'(pack(0, 7, 0, 0)));
    ack();

    // Random traffic: valid gaps, early/late acks, heavy weights, rare resets.
    for (int c = 0; c < 4000; c++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_spikes  = 4'($urandom);
      in_weight  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
      in_last    = ($urandom_range(0, 5) == 0);
      result_ack = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    result_ack = 1'b0;
    rst        = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
